// File: rtl/aes_ctr_ctrl_if.sv
// Handshake and data bundle between the CTR-mode controller, its data
// streams and the attached AES core.
interface aes_ctr_ctrl_if;
    logic [127:0] iv_in;
    logic         iv_load;
    logic         start;
    logic [15:0]  num_blocks;

    logic [127:0] din;
    logic         din_valid;
    logic         din_ready;

    logic [127:0] aes_in;
    logic         aes_start;
    logic [127:0] aes_out;
    logic         aes_done;

    logic [127:0] dout;
    logic         dout_valid;
    logic         dout_ready;

    logic         busy;
    logic         done;

    modport master (
        input  iv_in, iv_load, start, num_blocks,
        input  din, din_valid,
        input  aes_out, aes_done,
        input  dout_ready,
        output din_ready, aes_in, aes_start,
        output dout, dout_valid, busy, done
    );

    modport slave (
        output iv_in, iv_load, start, num_blocks,
        output din, din_valid,
        output aes_out, aes_done,
        output dout_ready,
        input  din_ready, aes_in, aes_start,
        input  dout, dout_valid, busy, done
    );
endinterface

// File: rtl/aes_ctr_ctrl.sv
// AES-CTR sequencer: per block, accepts plaintext, kicks the AES core with the
// counter block, XORs the keystream into the data and hands out ciphertext.
module aes_ctr_ctrl #(
    parameter int CTR_W = 32
) (
    input  logic          clk,
    input  logic          reset,
    aes_ctr_ctrl_if.master bus
);

    // Bits of the counter block that roll over; the rest (the nonce) never change.
    localparam logic [127:0] LOW_MASK =
        (CTR_W >= 128) ? {128{1'b1}} : ((128'd1 << CTR_W) - 128'd1);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_DIN,
        START_AES,
        WAIT_AES,
        OUTPUT
    } state_t;

    state_t       state_q, state_d;
    logic [127:0] ctr_q, ctr_d;
    logic [15:0]  remaining_q, remaining_d;
    logic [127:0] data_q, data_d;
    logic [127:0] dout_q, dout_d;
    logic         din_ready_q, din_ready_d;
    logic         aes_start_q, aes_start_d;
    logic         dout_valid_q, dout_valid_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;

    logic [127:0] ctr_inc;

    assign ctr_inc = (ctr_q & ~LOW_MASK) | ((ctr_q + 128'd1) & LOW_MASK);

    always_comb begin
        state_d     = state_q;
        ctr_d       = ctr_q;
        remaining_d = remaining_q;
        data_d      = data_q;
        dout_d      = dout_q;
        done_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.iv_load) begin
                    ctr_d = bus.iv_in;
                end
                if (bus.start) begin
                    if (bus.num_blocks != 16'd0) begin
                        remaining_d = bus.num_blocks;
                        state_d     = WAIT_DIN;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            WAIT_DIN: begin
                if (bus.din_valid && din_ready_q) begin
                    data_d  = bus.din;
                    state_d = START_AES;
                end
            end
            START_AES: begin
                state_d = WAIT_AES;
            end
            WAIT_AES: begin
                if (bus.aes_done) begin
                    dout_d      = bus.aes_out ^ data_q;
                    ctr_d       = ctr_inc;
                    remaining_d = remaining_q - 16'd1;
                    state_d     = OUTPUT;
                end
            end
            OUTPUT: begin
                if (bus.dout_ready) begin
                    if (remaining_q != 16'd0) begin
                        state_d = WAIT_DIN;
                    end else begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Strobes are decoded from the next state so they line up with the state flop.
        din_ready_d  = (state_d == WAIT_DIN);
        aes_start_d  = (state_d == START_AES);
        dout_valid_d = (state_d == OUTPUT);
        busy_d       = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            ctr_q        <= '0;
            remaining_q  <= '0;
            data_q       <= '0;
            dout_q       <= '0;
            din_ready_q  <= 1'b0;
            aes_start_q  <= 1'b0;
            dout_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            ctr_q        <= ctr_d;
            remaining_q  <= remaining_d;
            data_q       <= data_d;
            dout_q       <= dout_d;
            din_ready_q  <= din_ready_d;
            aes_start_q  <= aes_start_d;
            dout_valid_q <= dout_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign bus.aes_in     = ctr_q;
    assign bus.aes_start  = aes_start_q;
    assign bus.din_ready  = din_ready_q;
    assign bus.dout       = dout_q;
    assign bus.dout_valid = dout_valid_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;

endmodule

// File: doc/aes_ctr_ctrl.md
AES_CTR_CTRL -- requirements
Module: aes_ctr_ctrl

Interface
REQ-001 SHALL have parameter CTR_W, default 32, width of the incrementing low field of the counter block (1..128).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port iv_in  input  128  initial counter block (nonce || counter).
REQ-005 SHALL have port iv_load  input  1  load iv_in into counter register.
REQ-006 SHALL have port start  input  1  begin a run of num_blocks blocks.
REQ-007 SHALL have port num_blocks  input  16  block count for the run, sampled on accepted start.
REQ-008 SHALL have port din / din_valid / din_ready  input 128 / input 1 / output 1  plaintext stream, valid/ready handshake.
REQ-009 SHALL have port aes_in / aes_start  output 128 / output 1  counter block and one-cycle start pulse to AES core.
REQ-010 SHALL have port aes_out / aes_done  input 128 / input 1  keystream block and one-cycle completion pulse from AES core.
REQ-011 SHALL have port dout / dout_valid / dout_ready  output 128 / output 1 / input 1  ciphertext stream, valid/ready handshake.
REQ-012 SHALL have port busy / done  output 1 / output 1  run in progress; one-cycle pulse at run end.

Function
REQ-013 SHALL implement FSM states IDLE, WAIT_DIN, START_AES, WAIT_AES, OUTPUT.
REQ-014 IDLE: iv_load=1 SHALL set ctr<=iv_in; iv_load outside IDLE SHALL be ignored.
REQ-015 IDLE: start=1 with num_blocks>0 SHALL set remaining<=num_blocks and go to WAIT_DIN; start outside IDLE SHALL be ignored.
REQ-016 IDLE: start=1 with num_blocks=0 SHALL pulse done next cycle, stay IDLE, issue no aes_start.
REQ-017 iv_load and start in the same IDLE cycle SHALL both take effect; first block SHALL use the new iv_in.
REQ-018 WAIT_DIN: din_ready=1; on din_valid&din_ready SHALL capture din into data register, go to START_AES.
REQ-019 START_AES: aes_start=1 for exactly one cycle with aes_in=ctr; next state WAIT_AES.
REQ-020 WAIT_AES: on aes_done SHALL register dout<=aes_out XOR data, ctr[CTR_W-1:0]<=ctr[CTR_W-1:0]+1 mod 2^CTR_W, ctr[127:CTR_W] unchanged, remaining<=remaining-1, go to OUTPUT.
REQ-021 aes_done outside WAIT_AES SHALL be ignored.
REQ-022 OUTPUT: dout_valid=1, dout stable until dout_ready=1; on transfer go to WAIT_DIN if remaining>0, else pulse done and go to IDLE.
REQ-023 busy SHALL be 1 in every state except IDLE; din_ready SHALL be 0 outside WAIT_DIN.
REQ-024 aes_in SHALL equal ctr at all times; ctr SHALL persist across runs (next run continues from last value unless reloaded).
REQ-025 Minimum per-block latency, din accept to dout_valid, SHALL be 2 cycles + AES latency (aes_start cycle, aes_done capture cycle).

Reset
REQ-026 reset=1 SHALL immediately force state IDLE, ctr=0, remaining=0, data=0, dout=0, and all of din_ready, aes_start, dout_valid, busy, done = 0.
REQ-027 reset asserted mid-run SHALL abandon the run; any later aes_done SHALL be ignored.

Verification
REQ-028 iv_load iv_in=0x00..00_FFFFFFFE, start num_blocks=3, AES stub aes_out=aes_in -> aes_in sequence ...FFFFFFFE, ...FFFFFFFF, ...00000000 (upper 96 bits unchanged), one done pulse after third dout transfer.
REQ-029 din=0xA5..A5, aes_out=0x5A..5A -> dout=0xFF..FF; dout_ready held 0 for 5 cycles -> dout_valid and dout held stable, no ctr change.
REQ-030 start num_blocks=0 -> done pulse 1 cycle later, aes_start never asserted, busy stays 0.
REQ-031 start and iv_load asserted while busy -> ignored; ctr and remaining unaffected; spurious aes_done in WAIT_DIN ignored.
REQ-032 reset asserted in WAIT_AES, then aes_done -> all outputs 0, state IDLE, no dout_valid.
REQ-033 Back-to-back runs without iv_load: 2 blocks from iv 0x..10 then 2 blocks -> aes_in 0x10, 0x11, 0x12, 0x13.
